dmem_bridge: RTL

- Sits directly downstream of the single-cycle core's data-memory port.
- Converts the core's combinational request (mem_en/mem_we/mem_addr/mem_byte_sel/mem_wdata) into a registered valid/ready bus transaction with byte strobes, then returns lane-aligned read data on mem_rdata.
- Drives the core's halt input while an access is outstanding, so loads and stores tolerate arbitrary wait states.
- Flags misaligned accesses and bus timeouts.

---
 rtl/dmem_bridge_if.sv | 20 ++
 rtl/dmem_bridge.sv | 110 +++++++++++
 2 files changed

// File: rtl/dmem_bridge_if.sv
// dmem_bridge_if: registered valid/ready request channel plus response channel
// between the data-memory bridge (master) and the memory/bus (slave).
interface dmem_bridge_if;
  logic        bus_req_valid;
  logic        bus_req_ready;
  logic [31:0] bus_addr;
  logic        bus_we;
  logic [3:0]  bus_be;
  logic [31:0] bus_wdata;
  logic        bus_rsp_valid;
  logic [31:0] bus_rdata;
  modport master (
    output bus_req_valid, bus_addr, bus_we, bus_be, bus_wdata,
    input  bus_req_ready, bus_rsp_valid, bus_rdata
  );
  modport slave (
    input  bus_req_valid, bus_addr, bus_we, bus_be, bus_wdata,
    output bus_req_ready, bus_rsp_valid, bus_rdata
  );
endinterface

// File: rtl/dmem_bridge.sv
// dmem_bridge: turns the core's combinational data-memory request into a registered
// valid/ready bus transaction, stalling the core until the access retires.
module dmem_bridge #(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        mem_en,
  input  logic        mem_we,
  input  logic [31:0] mem_addr,
  input  logic [1:0]  mem_byte_sel,
  input  logic [31:0] mem_wdata,
  output logic [31:0] mem_rdata,
  output logic        halt,
  output logic        err_o,
  output logic [1:0]  err_code,
  dmem_bridge_if.master bus
);
  localparam int unsigned CW = TIMEOUT_CYCLES > 0 ? $clog2(TIMEOUT_CYCLES + 1) : 1;
  typedef enum logic [1:0] {IDLE, REQ, WAIT, DONE} state_t;
  state_t      state_q;
  logic [CW-1:0] cnt_q;
  logic [1:0]  off_q, sel_q, code_q;
  logic        we_q, req_valid_q, err_q;
  logic [3:0]  be_q;
  logic [31:0] addr_q, wdata_q, rdata_q;
  logic        mis_d, tmo_d;
  logic [3:0]  be_d;
  logic [31:0] wdata_d, sh_d, ld_d;
  assign mis_d = (mem_byte_sel == 2'b11) | (mem_byte_sel == 2'b01 & mem_addr[0]) |
                 (mem_byte_sel == 2'b10 & |mem_addr[1:0]);
  assign be_d = mem_byte_sel == 2'b00 ? 4'b0001 << mem_addr[1:0] :
                mem_byte_sel == 2'b01 ? (mem_addr[1] ? 4'b1100 : 4'b0011) : 4'b1111;
  assign wdata_d = mem_byte_sel == 2'b00 ? {4{mem_wdata[7:0]}} :
                   mem_byte_sel == 2'b01 ? {2{mem_wdata[15:0]}} : mem_wdata;
  assign sh_d = bus.bus_rdata >> {off_q, 3'b000};
  assign ld_d = sel_q == 2'b00 ? {24'h0, sh_d[7:0]} :
                sel_q == 2'b01 ? {16'h0, sh_d[15:0]} : sh_d;
  // Fires on the WAIT cycle whose increment would reach the limit, so exactly
  // TIMEOUT_CYCLES WAIT cycles elapse before giving up.
  assign tmo_d = (TIMEOUT_CYCLES != 0) && (32'(cnt_q) + 32'd1 == TIMEOUT_CYCLES);
  assign halt = (state_q == IDLE & mem_en) | state_q == REQ | state_q == WAIT;
  assign mem_rdata = rdata_q;
  assign err_o = err_q;
  assign err_code = code_q;
  assign bus.bus_req_valid = req_valid_q;
  assign bus.bus_addr = addr_q;
  assign bus.bus_we = we_q;
  assign bus.bus_be = be_q;
  assign bus.bus_wdata = wdata_q;
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q <= '0;
      off_q <= '0;
      sel_q <= '0;
      code_q <= '0;
      we_q <= 1'b0;
      req_valid_q <= 1'b0;
      err_q <= 1'b0;
      be_q <= '0;
      addr_q <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
    end else begin
      case (state_q)
        IDLE: if (mem_en) begin
          if (mis_d) begin
            state_q <= DONE;
            err_q <= 1'b1;
            code_q <= 2'b01;
            rdata_q <= '0;
          end else begin
            state_q <= REQ;
            req_valid_q <= 1'b1;
            addr_q <= {mem_addr[31:2], 2'b00};
            off_q <= mem_addr[1:0];
            sel_q <= mem_byte_sel;
            we_q <= mem_we;
            be_q <= be_d;
            wdata_q <= wdata_d;
          end
        end
        REQ: if (bus.bus_req_ready) begin
          state_q <= WAIT;
          req_valid_q <= 1'b0;
        end
        WAIT: if (bus.bus_rsp_valid) begin
          state_q <= DONE;
          cnt_q <= '0;
          if (!we_q) rdata_q <= ld_d;
        end else if (tmo_d) begin
          state_q <= DONE;
          cnt_q <= '0;
          err_q <= 1'b1;
          code_q <= 2'b10;
          rdata_q <= '0;
        end else begin
          cnt_q <= cnt_q + CW'(1);
        end
        DONE: begin
          state_q <= IDLE;
          err_q <= 1'b0;
          code_q <= 2'b00;
          cnt_q <= '0;
        end
      endcase
    end
  end
endmodule
